// File: rtl/video_sprite_pkg.sv
// Shared types and default geometry for the sprite overlay video cores.
// No logic; constants and typedefs only.
// Imported by video_sprite_render and video_sprite_pixcnt.
package video_sprite_pkg;

  localparam int PIX_W = 12;
  localparam int CRD_W = 11;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [CRD_W-1:0] coord_t;

  localparam int   DEF_H_RES = 640;
  localparam int   DEF_V_RES = 480;
  localparam int   DEF_SPR_W = 32;
  localparam int   DEF_SPR_H = 32;
  localparam pix_t DEF_KEY   = 12'h000;

endpackage

// File: rtl/video_sprite_pixcnt.sv
// Pixel position counter: px/py of the pixel currently presented, restarted by sof.
// Latency: position is combinational for the presented pixel; advances on adv.
// Backpressure: holds while adv is low, so a stalled pixel keeps its position.
module video_sprite_pixcnt
  import video_sprite_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   adv,
  input  logic   sof,
  output coord_t px,
  output coord_t py
);

  // Position of the next expected pixel; a sof beat overrides it with (0,0).
  coord_t nxt_x;
  coord_t nxt_y;

  assign px = sof ? '0 : nxt_x;
  assign py = sof ? '0 : nxt_y;

  // Step past the accepted pixel, wrapping at end of line and end of frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nxt_x <= '0;
      nxt_y <= '0;
    end else if (adv) begin
      if (px == coord_t'(H_RES - 1)) begin
        nxt_x <= '0;
        nxt_y <= (py == coord_t'(V_RES - 1)) ? '0 : py + 1'b1;
      end else begin
        nxt_x <= px + 1'b1;
        nxt_y <= py;
      end
    end
  end

endmodule

// File: rtl/video_sprite_render.sv
// Overlays one colour-keyed sprite from an external RAM onto a video stream.
// Latency: 2 cycles accept to dst_vld (S1 = RAM read, S2 = output register).
// Backpressure: global enable ce = !dst_vld || dst_rdy stalls whole pipe; src_rdy = ce.
// Optional: VIDEO_SPRITE_MIRROR_EN adds spr_mirror for a horizontal flip.
module video_sprite_render
  import video_sprite_pkg::*;
#(
  parameter int             H_RES = DEF_H_RES,
  parameter int             V_RES = DEF_V_RES,
  parameter int             SPR_W = DEF_SPR_W,
  parameter int             SPR_H = DEF_SPR_H,
  parameter int             AW    = 10,
  parameter int             DW    = PIX_W,
  parameter logic [DW-1:0]  KEY   = DEF_KEY
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spr_en,
  input  logic [10:0]   spr_x0,
  input  logic [10:0]   spr_y0,
`ifdef VIDEO_SPRITE_MIRROR_EN
  input  logic          spr_mirror,
`endif
  input  logic          src_vld,
  output logic          src_rdy,
  input  logic          src_sof,
  input  logic [DW-1:0] src_rgb,
  output logic          dst_vld,
  input  logic          dst_rdy,
  output logic          dst_sof,
  output logic [DW-1:0] dst_rgb,
  output logic [AW-1:0] ram_addr_r,
  input  logic [DW-1:0] ram_dout
);

  localparam int XB = $clog2(SPR_W);
  localparam int YB = $clog2(SPR_H);

  logic          ce;
  logic          acc;
  coord_t        px;
  coord_t        py;
  logic          en_sh;
  coord_t        x0_sh;
  coord_t        y0_sh;
  logic          en_c;
  coord_t        x0_c;
  coord_t        y0_c;
  logic [11:0]   dx;
  logic [11:0]   dy;
  logic          hit;
  logic [XB-1:0] xt;
  logic [AW-1:0] addr_new;
  logic [AW-1:0] addr_q;
  logic          s1_vld;
  logic          s1_sof;
  logic          s1_hit;
  logic [DW-1:0] s1_rgb;

  assign ce      = !dst_vld || dst_rdy;
  assign src_rdy = ce;
  assign acc     = src_vld && ce;

  video_sprite_pixcnt #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_pixcnt (
    .clk (clk),
    .rst (rst),
    .adv (acc),
    .sof (src_vld && src_sof),
    .px  (px),
    .py  (py)
  );

  // The sof pixel already sees the new position; later pixels see the shadow.
  assign en_c = src_sof ? spr_en : en_sh;
  assign x0_c = src_sof ? spr_x0 : x0_sh;
  assign y0_c = src_sof ? spr_y0 : y0_sh;

  // Capture sprite placement once per frame so mid-frame moves cannot tear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_sh <= 1'b0;
      x0_sh <= '0;
      y0_sh <= '0;
    end else if (acc && src_sof) begin
      en_sh <= spr_en;
      x0_sh <= spr_x0;
      y0_sh <= spr_y0;
    end
  end

  // Negative offsets show up in bit 11 and reject pixels left of / above the sprite.
  assign dx  = {1'b0, px} - {1'b0, x0_c};
  assign dy  = {1'b0, py} - {1'b0, y0_c};
  assign hit = en_c && !dx[11] && (dx < 12'(SPR_W)) && !dy[11] && (dy < 12'(SPR_H));

`ifdef VIDEO_SPRITE_MIRROR_EN
  logic        mir_sh;
  logic        mir_c;
  logic [11:0] dxm;

  assign mir_c = src_sof ? spr_mirror : mir_sh;
  assign dxm   = 12'(SPR_W - 1) - dx;
  assign xt    = mir_c ? dxm[XB-1:0] : dx[XB-1:0];

  // Flip flag follows the same once-per-frame capture as the position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 mir_sh <= 1'b0;
    else if (acc && src_sof) mir_sh <= spr_mirror;
  end
`else
  assign xt = dx[XB-1:0];
`endif

  assign addr_new = AW'({dy[YB-1:0], xt});

  // The RAM samples the address at the accept edge; while stalled the address
  // stays put so the RAM keeps returning the colour for the held S1 pixel.
  assign ram_addr_r = (acc && hit) ? addr_new : addr_q;

  // Remember the last presented address for hold cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_q <= '0;
    else     addr_q <= ram_addr_r;
  end

  // S1 waits for the RAM; S2 merges sprite colour over background unless keyed out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_sof  <= 1'b0;
      s1_hit  <= 1'b0;
      s1_rgb  <= '0;
      dst_vld <= 1'b0;
      dst_sof <= 1'b0;
      dst_rgb <= '0;
    end else if (ce) begin
      s1_vld  <= src_vld;
      s1_sof  <= src_vld && src_sof;
      s1_hit  <= src_vld && hit;
      s1_rgb  <= src_rgb;
      dst_vld <= s1_vld;
      dst_sof <= s1_sof;
      dst_rgb <= (s1_hit && (ram_dout != KEY)) ? ram_dout : s1_rgb;
    end
  end

endmodule

// File: doc/video_sprite_render.md
Name: video_sprite_render

Overview:
- Pixel-stream stage that overlays one sprite on the background video stream.
- Tracks the x/y position of each incoming pixel and tests it against the sprite window.
- Drives the read address of the sprite RAM (1-cycle registered read) and merges the returned colour with the background.
- Colour-key transparency is applied to the sprite colour.
- Sits between the upstream video core stream and the downstream sprite/output stage; the sprite RAM instance sits beside it.

Parameters:
- H_RES, 640, active pixels per line.
- V_RES, 480, active lines per frame.
- SPR_W, 32, sprite width in pixels; power of 2.
- SPR_H, 32, sprite height in pixels.
- AW, 10, sprite RAM address width; equals log2(SPR_W*SPR_H).
- DW, 12, pixel colour width (RGB444).
- KEY, 12'h000, transparent colour key.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- spr_en  in  1  sprite enable.
- spr_x0  in  11  sprite left column.
- spr_y0  in  11  sprite top line.
- src_vld  in  1  input pixel valid.
- src_rdy  out  1  input pixel ready.
- src_sof  in  1  first pixel of frame.
- src_rgb  in  DW  background pixel.
- dst_vld  out  1  output pixel valid.
- dst_rdy  in  1  output ready.
- dst_sof  out  1  output first pixel of frame.
- dst_rgb  out  DW  merged pixel.
- ram_addr_r  out  AW  sprite RAM read address.
- ram_dout  in  DW  sprite RAM read data; valid one cycle after the address.

Behaviour:
- Reset: dst_vld=0, dst_sof=0, dst_rgb=0, ram_addr_r=0. Counters, shadow registers and pipeline valids all clear to 0.
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Handshake: a beat transfers on vld&&rdy.
  - Global enable ce = !s2_vld || dst_rdy; src_rdy = ce.
  - Data must not change while vld=1 and rdy=0.
- Pipeline: S1 is the RAM-latency register, S2 is the output register. Latency is 2 cycles from input accept to dst_vld under no stall.
  - With ce=1, s1_vld<=src_vld, and s2_vld<=s1_vld.
- Pixel counters px, py:
  - On an accepted beat with src_sof=1, that pixel is (0,0).
  - Each other accepted beat: px++. When px reaches H_RES-1 it wraps to 0 and py++. When py reaches V_RES-1 it wraps to 0.
  - src_sof always forces (0,0), even mid-frame.
- Position shadow: spr_x0, spr_y0 and spr_en are latched into shadow registers only on an accepted sof beat; that sof pixel already uses the new values. Mid-frame changes have no effect until the next sof, so there is no tearing.
- Hit test on the current pixel:
  - dx = px - x0 and dy = py - y0, each 12 bits.
  - hit = en && !dx[11] && dx<SPR_W && !dy[11] && dy<SPR_H.
  - A sprite partially off-screen clips naturally.
- Address: ram_addr_r = {dy[log2 SPR_H-1:0], dx[log2 SPR_W-1:0]} when hit, otherwise held at its last value.
  - When ce=0, ram_addr_r is held at its previous value so ram_dout remains valid for the stalled S1 beat.
- Merge in S1->S2: dst_rgb <= (s1_hit && ram_dout!=KEY) ? ram_dout : s1_rgb. dst_sof follows the pipeline.
- Boundaries:
  - The sprite at x0=H_RES-SPR_W/2 shows only its left half.
  - The sprite at x0>=H_RES is never drawn.
  - A stall of any length preserves pixel order and values.
  - Reset mid-frame drops all in-flight beats; output resumes only after new input.

Optional Feature:
- Macro: VIDEO_SPRITE_MIRROR_EN.
- Defined: adds input port spr_mirror (1 bit), latched with the shadow registers at sof. When set, the address x term becomes SPR_W-1-dx, giving a horizontal flip.
- Undefined: no port and no flip logic; address as above.

Decomposition:
- Shared package video_sprite_pkg holds:
  - the pixel colour typedef (DW bits);
  - the coordinate typedef (11 bits);
  - default H_RES, V_RES, SPR_W, SPR_H and KEY constants.
- One natural sub-module: video_sprite_pixcnt (px/py counter with sof restart and wrap), reusable by other video cores.
- Merge and pipeline logic stay in the top module.

Test Plan:
- x0=100, y0=50, en=1, RAM filled with addr-based colours, dst_rdy=1 -> pixel (100,50) gives RAM[0]; (131,81) gives RAM[1023]; (99,50) and (132,50) give the background. Latency is exactly 2 cycles.
- RAM[5]=KEY at x0=0, y0=0 -> pixel (5,0) outputs src_rgb; (6,0) outputs RAM[6].
- x0=624 -> columns 624..639 of lines y0..y0+31 show RAM dx 0..15; no wrap into column 0 of the next line.
- Random dst_rdy at 30% ready over a full frame -> output sequence equals the no-stall golden model; src_rdy low whenever the S2 beat is held.
- Change spr_x0 from 100 to 200 at line 240 -> current frame unchanged; next frame drawn at 200.
- Assert rst at pixel (320,240), release, restart with sof -> dst_vld=0 during reset; first output is pixel (0,0) with dst_sof=1.
